tdm_mux_4_to_1: RTL and testbench
=================================

TDM_MUX_4_TO_1 -- requirements
Module: tdm_mux_4_to_1

Interface
REQ-001 Parameter WIDTH, default 8, data width of every channel and of the output.
REQ-002 Parameter CNT_W, default 8, width of each per-channel transfer counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  4  per-channel request; bit i means in_data for channel i is valid.
REQ-007 in_ready  output  4  per-channel accept; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a clk edge.
REQ-008 out_data  output  WIDTH  registered selected data.
REQ-009 out_sel  output  2  registered index of the channel that sourced out_data; this is the sel input of the downstream demux_1_to_4.
REQ-010 out_valid  output  1  out_data/out_sel hold a word.
REQ-011 out_ready  input  1  downstream accept; an output transfer occurs when out_valid and out_ready are both 1 at a clk edge.
REQ-012 cnt_clr  input  1  synchronous clear of all transfer counters.
REQ-013 xfer_cnt  output  4*CNT_W  per-channel accepted-word counters, channel i at [i*CNT_W +: CNT_W].

Function
REQ-014 The block has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The output register can load when state is EMPTY, or when state is FULL and out_ready=1 (pass-through load in the same cycle as the output transfer).
REQ-016 When the output register can load and at least one in_valid bit is 1, the arbiter grants exactly one channel; only that channel's in_ready is 1.
REQ-017 When the output register cannot load, or no in_valid bit is 1, all in_ready bits are 0.
REQ-018 in_ready is combinational from in_valid, out_ready, state and the priority pointer; it does not depend on in_data.
REQ-019 The arbitration is round-robin: search starts at (last+1) mod 4 and ascends with wrap-around (3 -> 0); last is the most recently granted channel.
REQ-020 last updates only on an accepted input transfer.
REQ-021 On a grant, out_data <= granted channel's data, out_sel <= granted index, state -> FULL; latency from input transfer to out_valid is 1 cycle.
REQ-022 FULL with out_ready=1 and no request: state -> EMPTY and out_valid=0 the next cycle.
REQ-023 FULL with out_ready=0: out_data and out_sel hold and all in_ready bits are 0.
REQ-024 A continuously requesting single channel is accepted every cycle while out_ready=1 (full throughput, no bubble).
REQ-025 With all four channels requesting and out_ready=1 held, grants rotate 0,1,2,3,0,... after reset; no channel waits more than 3 grants.
REQ-026 xfer_cnt[i] increments by 1 on each accepted transfer on channel i, and saturates at 2^CNT_W-1 with no wrap.
REQ-027 cnt_clr=1 zeroes all counters; clear has priority over a same-cycle increment.
REQ-028 in_valid bits for channels that are not granted have no effect on any state.

Reset
REQ-029 When rst_n=0, asynchronously: state=EMPTY, out_valid=0, out_data=0, out_sel=0, all xfer_cnt=0, last=3 (so channel 0 has first priority).
REQ-030 Reset mid-operation discards any held output word; no transfer is reported in the reset cycle, and in_ready=0 while rst_n=0.
REQ-031 The first grant can occur at the first clk edge after rst_n deasserts.

Structure
REQ-032 A shared package holds NUM_CH=4, SEL_W=2 and the two-value state enumeration (EMPTY, FULL).
REQ-033 The round-robin grant logic is a sub-module rr_arbiter_4: inputs req[3:0], last[1:0] and en; outputs gnt[3:0] (one-hot or zero) and gnt_idx[1:0].

Verification
REQ-034 Sequence: only ch2 valid, data 8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_sel=2, xfer_cnt[2]=1.
REQ-035 Sequence: all four channels valid (data 10,20,30,40), out_ready=1, held 8 cycles after reset -> out_sel sequence 0,1,2,3,0,1,2,3; each xfer_cnt=2.
REQ-036 Sequence: FULL with out_ready=0 for 5 cycles, all channels valid -> in_ready=0 and out_data stable throughout; when out_ready=1, the next grant goes to (last+1) mod 4.
REQ-037 Sequence: last=3, only ch0 and ch3 valid -> grant ch0, then ch3, then ch0 (wrap-around check).
REQ-038 Sequence: CNT_W=2, 5 transfers on ch1 -> xfer_cnt[1] saturates at 3; cnt_clr together with a ch1 transfer -> 0.
REQ-039 Sequence: assert rst_n=0 while FULL, between clk edges -> out_valid=0, out_sel=0 and counters=0 immediately; after release, the first grant goes to ch0 when all channels are valid.

Source files
------------

// File: rtl/tdm_mux_4_to_1_pkg.sv
// Shared constants and state encoding for the 4-to-1 time-division multiplexer.
// Imported by the arbiter and the top level.
package tdm_mux_4_to_1_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: the search starts one past the last granted
// channel and wraps 3 -> 0. The grant is one-hot, or zero when disabled or idle.
module rr_arbiter_4
  import tdm_mux_4_to_1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // The index arithmetic is SEL_W bits wide, so last+k wraps modulo 4 by itself.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + SEL_W'(k);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_4_to_1.sv
// Round-robin 4-to-1 TDM multiplexer with a one-word output register.
// It also keeps saturating per-channel counters of accepted words.
module tdm_mux_4_to_1
  import tdm_mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

  state_t              state;
  logic [SEL_W-1:0]    last;
  logic [NUM_CH-1:0]   gnt;
  logic [SEL_W-1:0]    gnt_idx;
  logic                can_load;
  logic                accept;
  logic [WIDTH-1:0]    ch_data [NUM_CH];

  // Gating with rst_n keeps every in_ready low while the block is held in reset.
  assign can_load = rst_n && ((state == EMPTY) || out_ready);

  rr_arbiter_4 u_arb (
    .req     (in_valid),
    .last    (last),
    .en      (can_load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready  = gnt;
  assign accept    = |gnt;
  assign out_valid = (state == FULL);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_data
    assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      last     <= SEL_W'(NUM_CH - 1);
    end else if (accept) begin
      state    <= FULL;
      out_data <= ch_data[gnt_idx];
      out_sel  <= gnt_idx;
      last     <= gnt_idx;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (gnt[gi] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign xfer_cnt[gi*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_tdm_mux_4_to_1.sv
// Self-checking bench for tdm_mux_4_to_1: directed sequences plus random traffic
// compared against a transaction-level model of the multiplexer.
module tb_tdm_mux_4_to_1;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          out_ready;
  logic          cnt_clr;
  logic [4*CW-1:0] xfer_cnt;

  int passed = 0;
  int total  = 0;

  // Model of the multiplexer: one held word plus the round-robin pointer.
  bit         m_full;
  logic [W-1:0] m_data;
  int         m_sel;
  int         m_last;
  int         m_cnt [4];

  always #5 clk = ~clk;

  tdm_mux_4_to_1 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
  );

  function automatic logic [3:0] exp_ready();
    int ch;
    if (!rst_n) return 4'b0;
    if (m_full && !out_ready) return 4'b0;
    for (int k = 1; k <= 4; k++) begin
      ch = (m_last + k) % 4;
      if (in_valid[ch]) return 4'(1 << ch);
    end
    return 4'b0;
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt();
    logic [4*CW-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_last = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Advance the model by one clock using the inputs now applied, then step the DUT.
  task automatic tick();
    logic [3:0] r;
    int ch;
    r  = exp_ready();
    ch = 0;
    for (int i = 0; i < 4; i++) if (r[i]) ch = i;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (r != 0 && m_cnt[ch] < MAXC) begin
        m_cnt[ch] = m_cnt[ch] + 1;
      end
      if (r != 0) begin
        m_full = 1'b1;
        m_data = in_data[ch*W +: W];
        m_sel  = ch;
        m_last = ch;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    cnt_clr  = 1'b0;
    in_data  = '1;
    model_reset();
    #2;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    total++;
    if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 00", out_data);
    else passed++;
    total++;
    if (out_sel !== 2'd0) $display("FAIL reset_out_sel: got %0d expected 0", out_sel);
    else passed++;
    total++;
    if (xfer_cnt !== '0) $display("FAIL reset_xfer_cnt: got %h expected 0", xfer_cnt);
    else passed++;
    total++;
    if (in_ready !== 4'b0) $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) $display("FAIL single_in_ready: got %b expected 0100", in_ready);
    else passed++;
    tick();
    in_valid = 4'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2)
      $display("FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=a5 s=2", out_valid, out_data, out_sel);
    else passed++;
    total++;
    if (xfer_cnt[2*CW +: CW] !== CW'(1)) $display("FAIL single_cnt2: got %0d expected 1", xfer_cnt[2*CW +: CW]);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    else passed++;
    $display("test_single done");
  endtask

  task automatic test_rotation();
    apply_reset();
    in_data   = {8'd40, 8'd30, 8'd20, 8'd10};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (in_ready !== 4'(1 << (i % 4))) $display("FAIL rot_in_ready[%0d]: got %b expected %b", i, in_ready, 4'(1 << (i % 4)));
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(10 * ((i % 4) + 1)))
        $display("FAIL rot_out[%0d]: got v=%b s=%0d d=%0d expected v=1 s=%0d d=%0d",
                 i, out_valid, out_sel, out_data, i % 4, 10 * ((i % 4) + 1));
      else passed++;
    end
    total++;
    if (xfer_cnt !== {CW'(2), CW'(2), CW'(2), CW'(2)}) $display("FAIL rot_cnt: got %h expected all 2", xfer_cnt);
    else passed++;
    $display("test_rotation done");
  endtask

  // Runs directly after test_rotation: output FULL holding ch3's word.
  task automatic test_stall();
    logic [W-1:0] held;
    held      = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      #1;
      total++;
      if (in_ready !== 4'b0) $display("FAIL stall_in_ready[%0d]: got %b expected 0000", i, in_ready);
      else passed++;
      tick();
      total++;
      if (out_data !== held || out_valid !== 1'b1 || out_sel !== 2'd3)
        $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=%h s=3", i, out_valid, out_data, out_sel, held);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'(1 << ((m_last + 1) % 4)) || in_ready !== 4'b0001)
      $display("FAIL stall_resume: got %b expected 0001", in_ready);
    else passed++;
    tick();
    total++;
    if (out_sel !== 2'd0) $display("FAIL stall_resume_sel: got %0d expected 0", out_sel);
    else passed++;
    $display("test_stall done");
  endtask

  task automatic test_wrap();
    int seq [3] = '{0, 3, 0};
    apply_reset();
    in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 4'(1 << seq[i])) $display("FAIL wrap_in_ready[%0d]: got %b expected %b", i, in_ready, 4'(1 << seq[i]));
      else passed++;
      tick();
      total++;
      if (out_sel !== 2'(seq[i])) $display("FAIL wrap_sel[%0d]: got %0d expected %0d", i, out_sel, seq[i]);
      else passed++;
    end
    $display("test_wrap done");
  endtask

  task automatic test_saturate();
    apply_reset();
    in_data   = {8'h00, 8'h00, 8'h5C, 8'h00};
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (xfer_cnt[1*CW +: CW] !== CW'((i < MAXC) ? i : MAXC))
        $display("FAIL sat_cnt1[%0d]: got %0d expected %0d", i, xfer_cnt[1*CW +: CW], (i < MAXC) ? i : MAXC);
      else passed++;
    end
    cnt_clr = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0010) $display("FAIL clr_in_ready: got %b expected 0010", in_ready);
    else passed++;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (xfer_cnt !== '0) $display("FAIL clr_cnt: got %h expected 0", xfer_cnt);
    else passed++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C) $display("FAIL clr_xfer: got v=%b d=%h expected v=1 d=5c", out_valid, out_data);
    else passed++;
    $display("test_saturate done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0) $display("FAIL arst_out: got v=%b s=%0d expected v=0 s=0", out_valid, out_sel);
    else passed++;
    total++;
    if (xfer_cnt !== '0) $display("FAIL arst_cnt: got %h expected 0", xfer_cnt);
    else passed++;
    total++;
    if (in_ready !== 4'b0) $display("FAIL arst_in_ready: got %b expected 0000", in_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || xfer_cnt !== '0) $display("FAIL arst_edge: got v=%b cnt=%h expected v=0 cnt=0", out_valid, xfer_cnt);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) $display("FAIL arst_first_gnt: got %b expected 0001", in_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'd1)
      $display("FAIL arst_first_out: got v=%b s=%0d d=%0d expected v=1 s=0 d=1", out_valid, out_sel, out_data);
    else passed++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [3:0] er;
    int fails_before;
    apply_reset();
    fails_before = total - passed;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      #1;
      er = exp_ready();
      total++;
      if (in_ready !== er) $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, er);
      else passed++;
      tick();
      total++;
      if (out_valid !== m_full) $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, m_full);
      else passed++;
      if (m_full) begin
        total++;
        if (out_data !== m_data || out_sel !== 2'(m_sel))
          $display("FAIL rnd_out[%0d]: got d=%h s=%0d expected d=%h s=%0d", i, out_data, out_sel, m_data, m_sel);
        else passed++;
      end
      total++;
      if (xfer_cnt !== exp_cnt()) $display("FAIL rnd_cnt[%0d]: got %h expected %h", i, xfer_cnt, exp_cnt());
      else passed++;
    end
    cnt_clr = 1'b0;
    $display("test_random done: %0d new failures", (total - passed) - fails_before);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_stall();
    test_wrap();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
